// File: rtl/weight_az_sched.sv
`default_nettype none
//==============================================================================
// Module      : weight_az_sched
// Description : Sequencer for the shared Weight_Az datapath. One start pulse
//               runs Weight_Az 2*NUM_SUBFR times. For each subframe it runs
//               once with gamma1 (writing Ap1) and once with gamma2 (writing
//               Ap2). While a batch is in progress the scratch memory is
//               granted to Weight_Az.
// Ports       : clk, reset (async, active high), start     - control in
//               done, busy, err                             - status out
//               A, AP, gammaAddr, job                       - job pointers out
//               wazStart / wazDone                          - datapath handshake
//               wazMuxSel, wazMux1Sel..wazMux3Sel           - memory mux selects
// Revision    : 1.0 - initial release
//==============================================================================
module weight_az_sched #(
    parameter int          NUM_SUBFR   = 2,
    parameter logic [11:0] A_BASE      = 12'd768,
    parameter logic [11:0] A_STRIDE    = 12'd16,
    parameter logic [11:0] AP1_BASE    = 12'd528,
    parameter logic [11:0] AP2_BASE    = 12'd560,
    parameter logic [11:0] GAMMA1_ADDR = 12'd448,
    parameter logic [11:0] GAMMA2_ADDR = 12'd449,
    parameter int          TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic [11:0] A,
    output logic [11:0] AP,
    output logic [11:0] gammaAddr,
    output logic        wazStart,
    input  logic        wazDone,
    output logic        wazMuxSel,
    output logic        wazMux1Sel,
    output logic        wazMux2Sel,
    output logic        wazMux3Sel,
    output logic [3:0]  job
);

    localparam logic [3:0] c_LAST_JOB = 4'(2 * NUM_SUBFR - 1);
    localparam int         c_CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TIMEOUT = c_CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t          r_state;
    logic [3:0]      r_k;
    logic [c_CW-1:0] r_cnt;
    logic            r_wazDoneQ;
    logic            r_memGrant;

    logic [3:0]      w_nextK;
    logic [11:0]     w_offset;
    logic [11:0]     w_nextA;
    logic [11:0]     w_nextAP;
    logic [11:0]     w_nextGamma;
    logic            w_doneRise;

    // Only a rising edge of wazDone completes a job, so a level still held
    // from the previous job cannot advance the sequence early.
    assign w_doneRise = wazDone & ~r_wazDoneQ;

    // Pointers for the job about to enter SETUP: job 0 when leaving IDLE,
    // otherwise the successor of the current job. Sums wrap at 12 bits.
    assign w_nextK     = (r_state == S_IDLE) ? 4'd0 : r_k + 4'd1;
    assign w_offset    = {9'd0, w_nextK[3:1]} * A_STRIDE;
    assign w_nextA     = A_BASE + w_offset;
    assign w_nextAP    = (w_nextK[0] ? AP2_BASE : AP1_BASE) + w_offset;
    assign w_nextGamma = w_nextK[0] ? GAMMA2_ADDR : GAMMA1_ADDR;

    // All four selects share one grant register so they can never disagree.
    assign wazMuxSel  = r_memGrant;
    assign wazMux1Sel = r_memGrant;
    assign wazMux2Sel = r_memGrant;
    assign wazMux3Sel = r_memGrant;
    assign job        = r_k;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_k        <= 4'd0;
            r_cnt      <= '0;
            r_wazDoneQ <= 1'b0;
            r_memGrant <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            wazStart   <= 1'b0;
            A          <= A_BASE;
            AP         <= AP1_BASE;
            gammaAddr  <= GAMMA1_ADDR;
        end else begin
            r_wazDoneQ <= wazDone;
            wazStart   <= 1'b0;
            done       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        r_k        <= w_nextK;
                        A          <= w_nextA;
                        AP         <= w_nextAP;
                        gammaAddr  <= w_nextGamma;
                        r_memGrant <= 1'b1;
                        r_state    <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    r_state <= S_ISSUE;
                end

                // wazStart is registered here, so it is seen two cycles after
                // the selects switched and never alongside a select change.
                S_ISSUE: begin
                    wazStart <= 1'b1;
                    r_cnt    <= '0;
                    r_state  <= S_WAIT;
                end

                // Completion takes priority over a timeout in the same cycle.
                S_WAIT: begin
                    if (w_doneRise) begin
                        if (r_k == c_LAST_JOB) begin
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            r_memGrant <= 1'b0;
                            r_state    <= S_FINISH;
                        end else begin
                            r_k       <= w_nextK;
                            A         <= w_nextA;
                            AP        <= w_nextAP;
                            gammaAddr <= w_nextGamma;
                            r_state   <= S_SETUP;
                        end
                    end else if (r_cnt == c_TIMEOUT) begin
                        err        <= 1'b1;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        r_memGrant <= 1'b0;
                        r_state    <= S_FINISH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // A start arriving here is dropped; the host re-issues it.
                S_FINISH: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
